// File: rtl/mac_array_q.sv
// -----------------------------------------------------------------------------
// mac_array_q
//
// Multi-lane signed fixed-point multiply-accumulate engine. Each lane
// accumulates either a*b or a bias term (sext(a) <<< FRAC). Beats are grouped
// into packets. The beat flagged in_last closes a packet: its sum is
// requantised to DATA_W with the selected rounding mode, clamped, and
// presented on dout with a per-lane saturation flag.
//
// Pipeline
//   S1  : registered per-lane term (sign-extended to ACC_W), valid, last, rnd.
//   S2  : accumulators. On the last beat the sum is quantised straight into the
//         output register and the accumulators clear on the same edge.
//   When a beat is accepted at edge t, its S1 entry exists after edge t. When
//   that beat is the last one, its result is on dout with out_valid=1 after
//   the following edge.
//
// Handshake (valid/ready, both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   Producers must hold valid and payload stable until the transfer happens.
//   in_ready = en = !out_valid || out_ready. The entire pipeline advances only
//   when en is high, so backpressure freezes every stage together.
//   in_ready depends on out_ready combinationally.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input beat handshake
//   in_last              beat closes the current packet
//   in_mode              0: term = a*b, 1: term = sext(a) <<< FRAC (b ignored)
//   rnd_mode             0: round toward zero, 1: round half-up (last beat)
//   din_a, din_b         signed operands, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready  result handshake
//   dout                 requantised results, same lane packing
//   sat_flag             per-lane flag: that lane's result was clamped
// -----------------------------------------------------------------------------
module mac_array_q #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 22,
  parameter int FRAC   = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic                    in_mode,
  input  logic                    rnd_mode,
  input  logic [LANES*DATA_W-1:0] din_a,
  input  logic [LANES*DATA_W-1:0] din_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] dout,
  output logic [LANES-1:0]        sat_flag
);

  // Width of the shifted-down sum, including one extra bit so that a
  // rounding increment cannot overflow.
  localparam int QW = ACC_W - FRAC + 1;
  // The clamp comparison uses a width that holds both QW-bit values and
  // DATA_W-bit bounds for any legal FRAC.
  localparam int CW = QW + DATA_W;
  localparam int PW = 2 * DATA_W;

  localparam logic signed [CW-1:0] Q_MAX = {{(QW+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [CW-1:0] Q_MIN = {{(QW+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Per-lane term: product, or bias aligned to the accumulator's binary point.
  // ---------------------------------------------------------------------------
  function automatic logic [ACC_W-1:0] make_term(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic              mode);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [PW-1:0]     p;
    logic [ACC_W-1:0]         a_ext;
    a_s   = a;
    b_s   = b;
    p     = a_s * b_s;
    a_ext = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
    if (mode) begin
      make_term = a_ext << FRAC;
    end else begin
      make_term = {{(ACC_W-PW){p[PW-1]}}, p};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Requantise one accumulator sum. Returns {sat, value[DATA_W-1:0]}.
  // The arithmetic shift floors the value. Round-toward-zero therefore
  // adds one back for negative sums that had discarded fraction bits.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W:0] requant(input logic [ACC_W-1:0] s,
                                              input logic             rnd);
    logic signed [QW-1:0] q;
    logic signed [CW-1:0] qx;
    logic                 inc;
    logic                 sat;
    logic [DATA_W-1:0]    val;
    q = {s[ACC_W-1], s[ACC_W-1:FRAC]};
    if (rnd) begin
      inc = s[FRAC-1];
    end else begin
      inc = s[ACC_W-1] & (|s[FRAC-1:0]);
    end
    q  = q + QW'(inc);
    qx = {{DATA_W{q[QW-1]}}, q};
    if (qx > Q_MAX) begin
      sat = 1'b1;
      val = Q_MAX[DATA_W-1:0];
    end else if (qx < Q_MIN) begin
      sat = 1'b1;
      val = Q_MIN[DATA_W-1:0];
    end else begin
      sat = 1'b0;
      val = qx[DATA_W-1:0];
    end
    requant = {sat, val};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q,  s1_last_d;
  logic                    s1_rnd_q,   s1_rnd_d;
  logic [ACC_W-1:0]        s1_term_q [LANES];
  logic [ACC_W-1:0]        s1_term_d [LANES];
  logic [ACC_W-1:0]        acc_q     [LANES];
  logic [ACC_W-1:0]        acc_d     [LANES];
  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] dout_q,      dout_d;
  logic [LANES-1:0]        sat_q,       sat_d;

  logic                    en;
  logic                    retire;
  logic [ACC_W-1:0]        sum [LANES];
  logic [DATA_W:0]         rq  [LANES];

  // Sum and requantised value per lane. Sums wrap modulo 2^ACC_W by design.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum[i] = acc_q[i] + s1_term_q[i];
      rq[i]  = requant(sum[i], s1_rnd_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Next state. Every register holds by default. It loads only when en is
  // high, so a stalled output freezes the whole pipeline without losing or
  // duplicating beats.
  // ---------------------------------------------------------------------------
  always_comb begin
    en          = !out_valid_q || out_ready;
    retire      = s1_valid_q && s1_last_q;

    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_rnd_d    = s1_rnd_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    for (int i = 0; i < LANES; i++) begin
      s1_term_d[i] = s1_term_q[i];
      acc_d[i]     = acc_q[i];
    end

    if (en) begin
      // S1 capture
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_last_d = in_last;
        s1_rnd_d  = rnd_mode;
        for (int i = 0; i < LANES; i++) begin
          s1_term_d[i] = make_term(din_a[i*DATA_W +: DATA_W],
                                   din_b[i*DATA_W +: DATA_W], in_mode);
        end
      end

      // S2 accumulate/retire. While en is high, out_valid reflects only
      // whether a new result arrives on this edge. The previous result was
      // either never valid or is being consumed on this edge.
      out_valid_d = retire;
      for (int i = 0; i < LANES; i++) begin
        if (s1_valid_q) begin
          acc_d[i] = retire ? '0 : sum[i];
        end
        if (retire) begin
          dout_d[i*DATA_W +: DATA_W] = rq[i][DATA_W-1:0];
          sat_d[i]                   = rq[i][DATA_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset discards any partial packet held in S1 and the
  // accumulators.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_rnd_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_term_q[i] <= '0;
        acc_q[i]     <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_rnd_q    <= s1_rnd_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
      for (int i = 0; i < LANES; i++) begin
        s1_term_q[i] <= s1_term_d[i];
        acc_q[i]     <= acc_d[i];
      end
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat_flag  = sat_q;

endmodule
